// File: rtl/mul_2x2_seq.sv
// Sequential WIDTHxWIDTH unsigned multiplier that time-shares a single 2x2 cell,
// one digit-pair partial product per cycle, with a start/done handshake.

module twoxtwo_mul (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic [3:0] p_o
);
   assign p_o = {2'b00, a_i} * {2'b00, b_i};
endmodule

module mul_2x2_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam int unsigned D  = WIDTH / 2;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
   localparam int unsigned SW = $clog2(PW);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
   logic [PW-1:0]     acc_q, acc_d, product_q, product_d;
   logic [IW-1:0]     i_q, i_d, j_q, j_d;
   logic              busy_q, busy_d, done_q, done_d;

   logic [1:0]        a_dig, b_dig;
   logic [3:0]        cell_p;
   logic [SW-1:0]     shamt;
   logic [PW-1:0]     pp;
   logic              i_last, j_last, last, accept;

   twoxtwo_mul u_cell (
      .a_i (a_dig),
      .b_i (b_dig),
      .p_o (cell_p)
   );

   // Digit select and partial-product alignment for the current (i, j) pair
   always_comb begin
      a_dig  = 2'(a_q >> {i_q, 1'b0});
      b_dig  = 2'(b_q >> {j_q, 1'b0});
      shamt  = SW'(SW'(i_q) + SW'(j_q)) << 1;
      pp     = PW'(cell_p) << shamt;
      i_last = (i_q == IW'(D - 1));
      j_last = (j_q == IW'(D - 1));
      last   = i_last && j_last;
      accept = start && (state_q != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last)  state_d = S_DONE;
         S_DONE:  state_d = start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; busy/done are decoded from the next state so they register cleanly
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      product_d = product_q;
      i_d       = i_q;
      j_d       = j_q;
      busy_d    = (state_d == S_RUN);
      done_d    = (state_d == S_DONE);
      if (accept) begin
         a_d   = a;
         b_d   = b;
         acc_d = '0;
         i_d   = '0;
         j_d   = '0;
      end else if (state_q == S_RUN) begin
         acc_d = acc_q + pp;
         if (j_last) begin
            j_d = '0;
            i_d = i_last ? '0 : i_q + IW'(1);
         end else begin
            j_d = j_q + IW'(1);
         end
         if (last) product_d = acc_q + pp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         i_q       <= '0;
         j_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         i_q       <= i_d;
         j_q       <= j_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_mul_2x2_seq.sv
// Directed checks of mul_2x2_seq at WIDTH=8, plus an exhaustive back-to-back sweep at WIDTH=4.

module tb_mul_2x2_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start8, start4;
   logic [7:0]  a8, b8;
   logic [3:0]  a4, b4;
   logic        busy8, done8, busy4, done4;
   logic [15:0] product8;
   logic [7:0]  product4;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mul_2x2_seq #(.WIDTH(8)) dut8 (
      .clk     (clk),
      .rst     (rst),
      .start   (start8),
      .a       (a8),
      .b       (b8),
      .busy    (busy8),
      .done    (done8),
      .product (product8)
   );

   mul_2x2_seq #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .rst     (rst),
      .start   (start4),
      .a       (a4),
      .b       (b4),
      .busy    (busy4),
      .done    (done4),
      .product (product4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one WIDTH=8 op from the current cycle (cycle 0) and check cycles 1..17.
   // A start pulse with FF x FF is injected in cycle pulse_cyc (0 = none).
   task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [15:0] prev_p, input logic [15:0] exp_p, input int pulse_cyc);
      start8 = 1'b1; a8 = av; b8 = bv;
      step();
      start8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
      for (int c = 1; c <= 16; c++) begin
         check_eq({tag, "_busy"}, 32'(busy8), 32'd1);
         check_eq({tag, "_nodone"}, 32'(done8), 32'd0);
         check_eq({tag, "_hold"}, 32'(product8), 32'(prev_p));
         if (c == pulse_cyc) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
         end
         step();
         start8 = 1'b0;
      end
      check_eq({tag, "_done"}, 32'(done8), 32'd1);
      check_eq({tag, "_busy_off"}, 32'(busy8), 32'd0);
      check_eq({tag, "_product"}, 32'(product8), 32'(exp_p));
   endtask

   initial begin
      rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      step(); start8 = 1'b1; step();
      check_eq("rst_busy", 32'(busy8), 32'd0);
      check_eq("rst_done", 32'(done8), 32'd0);
      check_eq("rst_product", 32'(product8), 32'd0);
      rst = 1'b0; start8 = 1'b0;
      step();

      // Max operands, then product holds in idle
      run8("max", 8'hFF, 8'hFF, 16'h0000, 16'hFE01, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("max_hold_done", 32'(done8), 32'd0);
         check_eq("max_hold_prod", 32'(product8), 32'hFE01);
      end

      // Mixed and zero operands
      run8("mix_a5", 8'hA5, 8'h3C, 16'hFE01, 16'h26AC, 0);
      step();
      run8("mix_zero", 8'h00, 8'h7F, 16'h26AC, 16'h0000, 0);
      step();
      run8("mix_one", 8'h01, 8'hFF, 16'h0000, 16'h00FF, 0);
      step();

      // Start during RUN is ignored
      run8("bsy_ign", 8'h12, 8'h34, 16'h00FF, 16'h03A8, 5);
      for (int k = 0; k < 20; k++) begin
         step();
         check_eq("bsy_ign_idle_busy", 32'(busy8), 32'd0);
         check_eq("bsy_ign_idle_done", 32'(done8), 32'd0);
      end

      // Back-to-back: second request presented in the done cycle
      run8("b2b_1", 8'h0F, 8'h0F, 16'h03A8, 16'h00E1, 0);
      run8("b2b_2", 8'h10, 8'h10, 16'h00E1, 16'h0100, 0);
      step();
      check_eq("b2b_idle_busy", 32'(busy8), 32'd0);

      // Reset mid-operation at cycle 8
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      step();
      start8 = 1'b0;
      for (int c = 1; c < 8; c++) step();
      check_eq("rmid_busy_before", 32'(busy8), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("rmid_busy", 32'(busy8), 32'd0);
      check_eq("rmid_done", 32'(done8), 32'd0);
      check_eq("rmid_product", 32'(product8), 32'd0);
      for (int k = 0; k < 20; k++) begin
         step();
         check_eq("rmid_no_done", 32'(done8), 32'd0);
      end
      run8("post_rst", 8'h03, 8'h05, 16'h0000, 16'h000F, 0);
      step();

      // Exhaustive WIDTH=4, all pairs back-to-back with start held high
      a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
      step();
      for (int k = 0; k < 256; k++) begin
         logic [7:0] ka, kb, kp;
         ka = 8'(k >> 4);
         kb = 8'(k & 15);
         kp = 8'(ka * kb);
         for (int c = 1; c <= 4; c++) begin
            check_eq("ex_busy", 32'(busy4), 32'd1);
            check_eq("ex_spacing", 32'(done4), 32'd0);
            step();
         end
         check_eq("ex_done", 32'(done4), 32'd1);
         check_eq("ex_excl", 32'(busy4 & done4), 32'd0);
         check_eq("ex_product", 32'(product4), 32'(kp));
         if (k < 255) begin
            a4 = 4'((k + 1) >> 4);
            b4 = 4'((k + 1) & 15);
         end else begin
            start4 = 1'b0;
         end
         step();
      end
      check_eq("ex_end_busy", 32'(busy4), 32'd0);
      check_eq("ex_end_done", 32'(done4), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
